// File: rtl/demux_n_chan_reg_if.sv
// Sample/control bus into the registered 1-to-N demultiplexer and its per-channel results.
interface demux_n_chan_reg_if #(
  parameter int W_CHAN = 16,
  parameter int W_SEL  = 4,
  parameter int N_OUT  = 8
) ();
  logic [W_CHAN-1:0]       data_in;
  logic                    dv_in;
  logic [W_SEL-1:0]        chan_select_in;
  logic                    auto_seq_in;
  logic                    clear_in;
  logic [W_CHAN*N_OUT-1:0] data_packed_out;
  logic [N_OUT-1:0]        dv_out;
  logic                    frame_dv_out;
  logic [W_SEL-1:0]        chan_cur_out;
  logic                    err_sel_out;

  modport master (
    output data_in, dv_in, chan_select_in, auto_seq_in, clear_in,
    input  data_packed_out, dv_out, frame_dv_out, chan_cur_out, err_sel_out
  );

  modport slave (
    input  data_in, dv_in, chan_select_in, auto_seq_in, clear_in,
    output data_packed_out, dv_out, frame_dv_out, chan_cur_out, err_sel_out
  );
endinterface

// File: rtl/demux_n_chan_reg.sv
// Registered 1-to-N demux: steers samples into N_OUT holding slots (manual or round-robin
// addressing) with per-channel update strobes and a frame strobe once every slot is refreshed.
module demux_chan_slot #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         dv
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q  <= '0;
      dv <= 1'b0;
    end else begin
      dv <= we;
      if (we) q <= d;
    end
  end
endmodule

module demux_n_chan_reg #(
  parameter int W_CHAN = 16,
  parameter int W_SEL  = 4,
  parameter int N_OUT  = 8
) (
  input logic              clk_in,
  input logic              rst_n_in,
  demux_n_chan_reg_if.slave bus
);
  localparam logic [W_SEL:0]   N_OUT_W  = (W_SEL+1)'(N_OUT);
  localparam logic [W_SEL-1:0] PTR_LAST = W_SEL'(N_OUT-1);
  localparam logic [N_OUT-1:0] ALL_ONES = '1;

  typedef enum logic {COLLECT, FRAME} state_t;

  typedef struct packed {
    logic              vld;
    logic [W_SEL-1:0]  tgt;
    logic [W_CHAN-1:0] data;
  } req_t;

  req_t                         req;
  logic                         in_range, acc, frame_hit;
  logic [N_OUT-1:0]             hit, nmask, mask;
  logic [W_SEL-1:0]             seq_ptr;
  logic                         err;
  state_t                       state, state_nxt;
  logic [N_OUT-1:0][W_CHAN-1:0] slot_q;
  logic [N_OUT-1:0]             dv_q;

  // clear wins over a coincident sample, so it simply masks the request
  always_comb begin
    req.vld  = bus.dv_in & ~bus.clear_in;
    req.tgt  = bus.auto_seq_in ? seq_ptr : bus.chan_select_in;
    req.data = bus.data_in;
  end

  assign in_range  = {1'b0, req.tgt} < N_OUT_W;
  assign acc       = req.vld & in_range;
  assign nmask     = mask | hit;
  assign frame_hit = acc && (nmask == ALL_ONES);

  for (genvar i = 0; i < N_OUT; i++) begin : g_chan
    assign hit[i] = acc && (req.tgt == W_SEL'(i));
    demux_chan_slot #(.W(W_CHAN)) u_slot (
      .clk   (clk_in),
      .rst_n (rst_n_in),
      .we    (hit[i]),
      .d     (req.data),
      .q     (slot_q[i]),
      .dv    (dv_q[i])
    );
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      seq_ptr <= '0;
      mask    <= '0;
      err     <= 1'b0;
    end else if (bus.clear_in) begin
      seq_ptr <= '0;
      mask    <= '0;
      err     <= 1'b0;
    end else begin
      if (bus.dv_in && bus.auto_seq_in)
        seq_ptr <= (seq_ptr == PTR_LAST) ? '0 : seq_ptr + 1'b1;
      if (acc)
        mask <= frame_hit ? '0 : nmask;
      if (req.vld && !in_range)
        err <= 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= COLLECT;
    else           state <= state_nxt;
  end

  // FRAME lasts exactly one cycle, lining up with the completing dv_out bit
  always_comb begin
    state_nxt = COLLECT;
    if (frame_hit) state_nxt = FRAME;
  end

  always_comb begin
    bus.frame_dv_out = 1'b0;
    if (state == FRAME) bus.frame_dv_out = 1'b1;
  end

  assign bus.data_packed_out = slot_q;
  assign bus.dv_out          = dv_q;
  assign bus.chan_cur_out    = seq_ptr;
  assign bus.err_sel_out     = err;
endmodule

// File: tb/tb_demux_n_chan_reg.sv
// Directed bench for demux_n_chan_reg (N_OUT=8, W_SEL=4, W_CHAN=16).
module tb_demux_n_chan_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  demux_n_chan_reg_if #(.W_CHAN(16), .W_SEL(4), .N_OUT(8)) bus ();

  demux_n_chan_reg #(.W_CHAN(16), .W_SEL(4), .N_OUT(8)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  function automatic logic [15:0] slot(input int i);
    return bus.data_packed_out[i*16 +: 16];
  endfunction

  task automatic drive(input logic dv, input logic [3:0] sel, input logic auto,
                       input logic clr, input logic [15:0] d);
    bus.dv_in          = dv;
    bus.chan_select_in = sel;
    bus.auto_seq_in    = auto;
    bus.clear_in       = clr;
    bus.data_in        = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.dv_in = 0; bus.chan_select_in = 0; bus.auto_seq_in = 0; bus.clear_in = 0; bus.data_in = 0;
    rst_n = 1'b0;
    #12;
    tests++; if (bus.data_packed_out !== 128'h0) begin fails++; $display("FAIL reset_data got %h want 0", bus.data_packed_out); end
    tests++; if (bus.dv_out !== 8'h00) begin fails++; $display("FAIL reset_dv got %h want 00", bus.dv_out); end
    tests++; if (bus.frame_dv_out !== 1'b0) begin fails++; $display("FAIL reset_frame got %b want 0", bus.frame_dv_out); end
    tests++; if (bus.chan_cur_out !== 4'd0) begin fails++; $display("FAIL reset_ptr got %0d want 0", bus.chan_cur_out); end
    tests++; if (bus.err_sel_out !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", bus.err_sel_out); end
    rst_n = 1'b1;
  endtask

  task automatic test_manual;
    logic [127:0] e;
    e = '0;
    e[63:48] = 16'h1111;
    drive(1, 4'd3, 0, 0, 16'h1111);
    tests++; if (bus.data_packed_out !== e) begin fails++; $display("FAIL manual_data got %h want %h", bus.data_packed_out, e); end
    tests++; if (bus.dv_out !== 8'b0000_1000) begin fails++; $display("FAIL manual_dv got %b want 00001000", bus.dv_out); end
    tests++; if (bus.frame_dv_out !== 1'b0) begin fails++; $display("FAIL manual_frame got %b want 0", bus.frame_dv_out); end
    drive(0, 0, 0, 0, 0);
    tests++; if (bus.dv_out !== 8'h00) begin fails++; $display("FAIL manual_dv_drop got %b want 0", bus.dv_out); end
    tests++; if (slot(3) !== 16'h1111) begin fails++; $display("FAIL manual_hold got %h want 1111", slot(3)); end
  endtask

  task automatic test_auto_rr;
    logic [7:0] e;
    drive(0, 0, 0, 1, 0);
    tests++; if (bus.chan_cur_out !== 4'd0) begin fails++; $display("FAIL rr_clear_ptr got %0d want 0", bus.chan_cur_out); end
    for (int i = 0; i < 8; i++) begin
      drive(1, 4'd0, 1, 0, 16'(i));
      e = 8'd1 << i;
      tests++; if (bus.dv_out !== e) begin fails++; $display("FAIL rr_dv%0d got %b want %b", i, bus.dv_out, e); end
      tests++; if (slot(i) !== 16'(i)) begin fails++; $display("FAIL rr_slot%0d got %h want %h", i, slot(i), 16'(i)); end
      tests++; if (bus.frame_dv_out !== (i == 7)) begin fails++; $display("FAIL rr_frame%0d got %b want %b", i, bus.frame_dv_out, (i == 7)); end
      tests++; if (bus.chan_cur_out !== 4'((i + 1) % 8)) begin fails++; $display("FAIL rr_ptr%0d got %0d want %0d", i, bus.chan_cur_out, (i + 1) % 8); end
    end
    drive(1, 4'd0, 1, 0, 16'h0008);
    tests++; if (slot(0) !== 16'h0008) begin fails++; $display("FAIL rr_wrap_slot got %h want 0008", slot(0)); end
    tests++; if (bus.dv_out !== 8'h01) begin fails++; $display("FAIL rr_wrap_dv got %b want 00000001", bus.dv_out); end
    tests++; if (bus.frame_dv_out !== 1'b0) begin fails++; $display("FAIL rr_wrap_frame got %b want 0", bus.frame_dv_out); end
    tests++; if (bus.chan_cur_out !== 4'd1) begin fails++; $display("FAIL rr_wrap_ptr got %0d want 1", bus.chan_cur_out); end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_dup_oor;
    logic [127:0] snap;
    drive(0, 0, 0, 1, 0);
    drive(1, 4'd2, 0, 0, 16'hAAAA);
    tests++; if (bus.dv_out !== 8'h04) begin fails++; $display("FAIL dup_dv1 got %b want 00000100", bus.dv_out); end
    drive(1, 4'd2, 0, 0, 16'hBBBB);
    tests++; if (bus.dv_out !== 8'h04) begin fails++; $display("FAIL dup_dv2 got %b want 00000100", bus.dv_out); end
    tests++; if (slot(2) !== 16'hBBBB) begin fails++; $display("FAIL dup_slot got %h want BBBB", slot(2)); end
    snap = bus.data_packed_out;
    drive(1, 4'd9, 0, 0, 16'hCCCC);
    tests++; if (bus.dv_out !== 8'h00) begin fails++; $display("FAIL oor_dv got %b want 0", bus.dv_out); end
    tests++; if (bus.data_packed_out !== snap) begin fails++; $display("FAIL oor_data got %h want %h", bus.data_packed_out, snap); end
    tests++; if (bus.err_sel_out !== 1'b1) begin fails++; $display("FAIL oor_err got %b want 1", bus.err_sel_out); end
    drive(0, 0, 0, 0, 0);
    drive(1, 4'd1, 0, 0, 16'h0101);
    tests++; if (bus.err_sel_out !== 1'b1) begin fails++; $display("FAIL oor_sticky got %b want 1", bus.err_sel_out); end
    drive(0, 0, 0, 1, 0);
    tests++; if (bus.err_sel_out !== 1'b0) begin fails++; $display("FAIL oor_clear got %b want 0", bus.err_sel_out); end
    tests++; if (slot(2) !== 16'hBBBB) begin fails++; $display("FAIL clear_keep got %h want BBBB", slot(2)); end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_clear_collision;
    logic [15:0] s5;
    drive(1, 0, 1, 0, 16'h0C00);
    drive(1, 0, 1, 0, 16'h0C01);
    s5 = slot(5);
    drive(1, 4'd5, 0, 1, 16'hBEEF);
    tests++; if (slot(5) !== s5) begin fails++; $display("FAIL coll_slot got %h want %h", slot(5), s5); end
    tests++; if (bus.dv_out !== 8'h00) begin fails++; $display("FAIL coll_dv got %b want 0", bus.dv_out); end
    tests++; if (bus.chan_cur_out !== 4'd0) begin fails++; $display("FAIL coll_ptr got %0d want 0", bus.chan_cur_out); end
    for (int i = 0; i < 8; i++) begin
      drive(1, 4'(i), 0, 0, 16'(16'h0100 + i));
      tests++; if (bus.frame_dv_out !== (i == 7)) begin fails++; $display("FAIL coll_frame%0d got %b want %b", i, bus.frame_dv_out, (i == 7)); end
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) drive(1, 4'(i), 0, 0, 16'(16'h0D00 + i));
    #3 rst_n = 1'b0;
    #1;
    tests++; if (bus.data_packed_out !== 128'h0) begin fails++; $display("FAIL rmid_data got %h want 0", bus.data_packed_out); end
    tests++; if (bus.dv_out !== 8'h00) begin fails++; $display("FAIL rmid_dv got %b want 0", bus.dv_out); end
    bus.dv_in = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1, 4'(i), 0, 0, 16'(16'h0E00 + i));
      tests++; if (bus.frame_dv_out !== (i == 7)) begin fails++; $display("FAIL rmid_frame%0d got %b want %b", i, bus.frame_dv_out, (i == 7)); end
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_mode_toggle;
    logic [7:0] e;
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 0, 16'(16'h0A00 + i));
    tests++; if (bus.chan_cur_out !== 4'd3) begin fails++; $display("FAIL tog_ptr3 got %0d want 3", bus.chan_cur_out); end
    drive(1, 4'd7, 0, 0, 16'h0A07);
    tests++; if (bus.dv_out !== 8'h80) begin fails++; $display("FAIL tog_man_dv got %b want 10000000", bus.dv_out); end
    tests++; if (bus.chan_cur_out !== 4'd3) begin fails++; $display("FAIL tog_ptr_hold got %0d want 3", bus.chan_cur_out); end
    for (int c = 3; c < 7; c++) begin
      drive(1, 4'd0, 1, 0, 16'(16'h0A00 + c));
      e = 8'd1 << c;
      tests++; if (bus.dv_out !== e) begin fails++; $display("FAIL tog_dv%0d got %b want %b", c, bus.dv_out, e); end
      tests++; if (slot(c) !== 16'(16'h0A00 + c)) begin fails++; $display("FAIL tog_slot%0d got %h want %h", c, slot(c), 16'(16'h0A00 + c)); end
      tests++; if (bus.frame_dv_out !== (c == 6)) begin fails++; $display("FAIL tog_frame%0d got %b want %b", c, bus.frame_dv_out, (c == 6)); end
    end
    tests++; if (bus.chan_cur_out !== 4'd7) begin fails++; $display("FAIL tog_ptr_end got %0d want 7", bus.chan_cur_out); end
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_manual();
    test_auto_rr();
    test_dup_oor();
    test_clear_collision();
    test_reset_mid();
    test_mode_toggle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
